// File: rtl/urv_console_uart.sv
// rtl/urv_console_uart.sv - uRV console/test-status peripheral with FIFO-buffered 8N1 UART transmitter
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   dm_addr_i           CPU data address (full 32-bit match)
//   dm_data_s_i         CPU store data
//   dm_data_select_i    byte-lane enables (lane 0 gates console pushes)
//   dm_store_i          one-cycle store strobe
//   dm_ready_o          low while the console FIFO is full
//   dm_store_done_o     one-cycle ack of a store to a mapped address
//   clear_i             clears test_done_o, test_code_o, overflow_o
//   uart_txd_o          8N1 serial output, idle high
//   tx_busy_o           FIFO non-empty or frame in flight
//   test_done_o         sticky flag: status word written
//   test_code_o         last status word written
//   overflow_o          sticky flag: console byte dropped on a full FIFO
module urv_console_uart #(
  parameter int unsigned g_baud_div     = 16,
  parameter int unsigned g_fifo_depth   = 16,
  parameter logic [31:0] g_console_addr = 32'h0010_0000,
  parameter logic [31:0] g_status_addr  = 32'h0010_0004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic        dm_store_done_o,
  input  logic        clear_i,
  output logic        uart_txd_o,
  output logic        tx_busy_o,
  output logic        test_done_o,
  output logic [31:0] test_code_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(g_fifo_depth);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(g_baud_div);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(g_baud_div - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            pop;

  logic [7:0]      mem [g_fifo_depth];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty;

  logic            console_hit, status_hit, push_req, push;
  logic            unused_sel;

  assign unused_sel  = ^dm_data_select_i[3:1];

  assign console_hit = dm_store_i && (dm_addr_i == g_console_addr);
  assign status_hit  = dm_store_i && (dm_addr_i == g_status_addr);
  assign push_req    = console_hit && dm_data_select_i[0];
  // Fullness is judged on the registered count only; a same-cycle pop does not make room.
  assign push        = push_req && !full;

  assign full        = (count == CW'(g_fifo_depth));
  assign empty       = (count == '0);
  assign dm_ready_o  = !full;
  assign tx_busy_o   = (state != IDLE) || !empty;

  // Console FIFO
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= dm_data_s_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Store acknowledge, test status and overflow flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dm_store_done_o <= 1'b0;
      test_done_o     <= 1'b0;
      test_code_o     <= '0;
      overflow_o      <= 1'b0;
    end else begin
      dm_store_done_o <= console_hit || status_hit;
      // A status store in the same cycle as clear_i takes priority.
      if (status_hit) begin
        test_done_o <= 1'b1;
        test_code_o <= dm_data_s_i;
      end else if (clear_i) begin
        test_done_o <= 1'b0;
        test_code_o <= '0;
      end
      if (push_req && full) overflow_o <= 1'b1;
      else if (clear_i)     overflow_o <= 1'b0;
    end
  end

  // TX FSM: state register and datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= BAUD_RELOAD;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || (state == DATA && baud_cnt == '0))
        baud_cnt <= BAUD_RELOAD;
      else if (baud_cnt != '0)
        baud_cnt <= baud_cnt - 1'b1;

      if (pop) begin
        shift <= mem[rd_ptr];
      end else if (state == DATA && baud_cnt == '0) begin
        shift <= shift >> 1;
      end

      if (state != DATA)        bit_cnt <= '0;
      else if (baud_cnt == '0)  bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // TX FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!empty) state_next = START;
      START: if (baud_cnt == '0) state_next = DATA;
      DATA:  if (baud_cnt == '0 && bit_cnt == 3'd7) state_next = STOP;
      STOP:  if (baud_cnt == '0) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // TX FSM: outputs
  always_comb begin
    uart_txd_o = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE:  pop = !empty;
      START: uart_txd_o = 1'b0;
      DATA:  uart_txd_o = shift[0];
      // Popping on the last stop cycle chains the next frame with no idle gap.
      STOP:  pop = (baud_cnt == '0) && !empty;
      default: uart_txd_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_urv_console_uart.sv
// tb/tb_urv_console_uart.sv - directed self-checking bench for urv_console_uart
module tb_urv_console_uart;

  localparam logic [31:0] CONSOLE = 32'h0010_0000;
  localparam logic [31:0] STATUS  = 32'h0010_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel = '0;
  logic        store = 1'b0;
  logic        clear = 1'b0;
  logic        ready, store_done, txd, busy, done, ovf;
  logic [31:0] code;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  urv_console_uart #(
    .g_baud_div(4),
    .g_fifo_depth(4),
    .g_console_addr(CONSOLE),
    .g_status_addr(STATUS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .dm_addr_i(addr),
    .dm_data_s_i(wdata),
    .dm_data_select_i(sel),
    .dm_store_i(store),
    .dm_ready_o(ready),
    .dm_store_done_o(store_done),
    .clear_i(clear),
    .uart_txd_o(txd),
    .tx_busy_o(busy),
    .test_done_o(done),
    .test_code_o(code),
    .overflow_o(ovf)
  );

  // Drives one store for one cycle; returns at the falling edge after the sampling edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; sel = s; store = 1'b1;
    @(negedge clk);
    store = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (store_done !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", store_done); end
    checks++; if ({done, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {done, ovf}); end
    checks++; if (code !== 32'h0) begin errors++; $display("FAIL reset_code got %h want 0", code); end
  endtask

  task automatic test_frame();
    logic [9:0] exp_bits;
    exp_bits = {1'b1, 8'h41, 1'b0};
    do_store(CONSOLE, 32'h0000_0041, 4'b0001);
    checks++; if (store_done !== 1'b1) begin errors++; $display("FAIL frame_ack got %b want 1", store_done); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL frame_txd_e0 got %b want 1", txd); end
    @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL frame_fall got %b want 0", txd); end
    for (int i = 0; i < 10; i++) begin
      repeat ((i == 0) ? 2 : 4) @(negedge clk);
      checks++;
      if (txd !== exp_bits[i]) begin errors++; $display("FAIL frame_bit%0d got %b want %b", i, txd, exp_bits[i]); end
    end
    @(negedge clk);
    checks++; if ({txd, busy} !== 2'b11) begin errors++; $display("FAIL frame_end_40 got %b want 11", {txd, busy}); end
    @(negedge clk);
    checks++; if ({txd, busy} !== 2'b10) begin errors++; $display("FAIL frame_idle_41 got %b want 10", {txd, busy}); end
  endtask

  task automatic test_status_clear();
    do_store(STATUS, 32'h0000_0001, 4'b0001);
    checks++; if (store_done !== 1'b1) begin errors++; $display("FAIL status_ack got %b want 1", store_done); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL status_done got %b want 1", done); end
    checks++; if (code !== 32'h1) begin errors++; $display("FAIL status_code got %h want 1", code); end
    @(negedge clk);
    checks++; if (store_done !== 1'b0) begin errors++; $display("FAIL status_ack_pulse got %b want 0", store_done); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if ({done, code} !== 33'h0) begin errors++; $display("FAIL clear done=%b code=%h want 0/0", done, code); end
  endtask

  task automatic test_clear_vs_store();
    do_store(STATUS, 32'h1234_5678, 4'b1111);
    clear = 1'b1;
    do_store(STATUS, 32'hDEAD_0000, 4'b1111);
    clear = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clr_vs_store_done got %b want 1", done); end
    checks++; if (code !== 32'hDEAD_0000) begin errors++; $display("FAIL clr_vs_store_code got %h want dead0000", code); end
  endtask

  task automatic test_unmapped();
    do_store(32'h0010_0008, 32'h0000_0055, 4'b0001);
    checks++; if (store_done !== 1'b0) begin errors++; $display("FAIL unmapped_ack got %b want 0", store_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unmapped_push got busy %b want 0", busy); end
    do_store(CONSOLE, 32'h0000_0055, 4'b0010);
    checks++; if (store_done !== 1'b1) begin errors++; $display("FAIL lane_ack got %b want 1", store_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lane_push got busy %b want 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL lane_txd got %b want 1", txd); end
  endtask

  // Receives one frame by sampling at bit centres; reports the cycle of the start-bit fall.
  task automatic rx_frame(input logic [7:0] expected, input string tag, output int fall_cyc);
    int   waited;
    logic [7:0] got;
    waited = 0;
    fall_cyc = -1;
    while (txd !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (txd !== 1'b0) begin
      errors++; $display("FAIL %s no start bit within 200 cycles", tag);
    end else begin
      fall_cyc = cyc;
      repeat (2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (4) @(negedge clk);
        got[b] = txd;
      end
      repeat (4) @(negedge clk);
      if (got !== expected || txd !== 1'b1) begin
        errors++; $display("FAIL %s got %h stop %b want %h stop 1", tag, got, txd, expected);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ready [6];
    int   falls [5];
    exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    fork
      begin
        addr = CONSOLE; sel = 4'b0001; store = 1'b1;
        for (int i = 0; i < 6; i++) begin
          wdata = 32'h10 + i;
          @(negedge clk);
          checks++;
          if (ready !== exp_ready[i]) begin errors++; $display("FAIL fifo_ready_%0d got %b want %b", i, ready, exp_ready[i]); end
        end
        store = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL overflow got %b want 1", ovf); end
      end
      begin
        for (int f = 0; f < 5; f++) begin
          int fc;
          rx_frame(8'h10 + 8'(f), $sformatf("b2b_byte%0d", f), fc);
          falls[f] = fc;
          if (f > 0) begin
            checks++;
            if (falls[f] - falls[f-1] !== 40) begin
              errors++; $display("FAIL b2b_gap%0d got %0d want 40", f, falls[f] - falls[f-1]);
            end
          end
        end
      end
    join
    repeat (60) @(negedge clk);
    checks++; if ({txd, busy} !== 2'b10) begin errors++; $display("FAIL b2b_drained got %b want 10", {txd, busy}); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b want 0", ovf); end
  endtask

  task automatic test_reset_mid_frame();
    logic stayed_high;
    for (int i = 0; i < 3; i++) do_store(CONSOLE, 32'h0000_00A0 + i, 4'b0001);
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_frame_busy got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stayed_high = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
    end
    checks++; if (stayed_high !== 1'b1) begin errors++; $display("FAIL rst_no_resume got activity after reset"); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_status_clear();
    test_clear_vs_store();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
